// File: rtl/div_radix2_if.sv
// Operand and result handshakes between the MDU stage-2/3 logic and the radix-2 divider.
interface div_radix2_if #(
    parameter int unsigned WIDTH = 32
);
    logic             div_valid;
    logic             div_ready;
    logic             div_signed_i;
    logic [WIDTH-1:0] Z_i;
    logic [WIDTH-1:0] D_i;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] q_o;
    logic [WIDTH-1:0] s_o;

    modport master (
        output div_valid, div_signed_i, Z_i, D_i, res_ready,
        input  div_ready, res_valid, q_o, s_o
    );

    modport slave (
        input  div_valid, div_signed_i, Z_i, D_i, res_ready,
        output div_ready, res_valid, q_o, s_o
    );
endinterface

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider (DIV/MOD engine). Define DIV_CLZ_SKIP_EN to skip
// the leading zeros of the dividend with a CLZ pre-shift at accept.
module div_radix2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    div_radix2_if.slave   div
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dabs_q, dabs_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] s_q, s_d;

    logic [WIDTH-1:0] z_abs, d_abs;
    logic [WIDTH:0]   shifted, diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_nxt, dvd_nxt, q_fix, s_fix;

`ifdef DIV_CLZ_SKIP_EN
    function automatic logic [CntW:0] clz(input logic [WIDTH-1:0] v);
        logic [CntW:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n     = n + 1'b1;
            end
        end
        return n;
    endfunction

    logic [CntW:0] z_lz;
    assign z_lz = clz(z_abs);
`endif

    assign z_abs = (div.div_signed_i && div.Z_i[WIDTH-1]) ? -div.Z_i : div.Z_i;
    assign d_abs = (div.div_signed_i && div.D_i[WIDTH-1]) ? -div.D_i : div.D_i;

    // The partial remainder stays below |D|, so only the WIDTH+1-bit trial needs the extra bit.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dabs_q};
    assign qbit    = ~diff[WIDTH];
    assign rem_nxt = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign dvd_nxt = {dvd_q[WIDTH-2:0], qbit};

    // Divide by zero yields all ones; the remainder path already reproduces the raw dividend.
    assign q_fix = dz_q ? '1 : (qsign_q ? -dvd_nxt : dvd_nxt);
    assign s_fix = rsign_q ? -rem_nxt : rem_nxt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dabs_d  = dabs_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        dz_d    = dz_q;
        q_d     = q_q;
        s_d     = s_q;

        unique case (state_q)
            StIdle: begin
                if (div.div_valid) begin
                    state_d = StCalc;
                    rem_d   = '0;
                    dabs_d  = d_abs;
                    qsign_d = div.div_signed_i & (div.Z_i[WIDTH-1] ^ div.D_i[WIDTH-1]);
                    rsign_d = div.div_signed_i & div.Z_i[WIDTH-1];
                    dz_d    = (div.D_i == '0);
`ifdef DIV_CLZ_SKIP_EN
                    dvd_d = z_abs << z_lz;
                    cnt_d = CntW'(32'(WIDTH) - 32'(z_lz) - 32'd1);
                    if (z_abs == '0) begin
                        state_d = StDone;
                        q_d     = (div.D_i == '0) ? '1 : '0;
                        s_d     = '0;
                    end
`else
                    dvd_d = z_abs;
                    cnt_d = CntW'(WIDTH - 1);
`endif
                end
            end
            StCalc: begin
                rem_d = rem_nxt;
                dvd_d = dvd_nxt;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StDone;
                    q_d     = q_fix;
                    s_d     = s_fix;
                end
            end
            StDone: begin
                if (div.res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dabs_q  <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
            q_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dabs_q  <= dabs_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            dz_q    <= dz_d;
            q_q     <= q_d;
            s_q     <= s_d;
        end
    end

    assign div.div_ready = (state_q == StIdle);
    assign div.res_valid = (state_q == StDone);
    assign div.q_o       = q_q;
    assign div.s_o       = s_q;
endmodule

// File: tb/tb_div_radix2.sv
// Directed-vector bench for div_radix2: table of operand/result records plus handshake corners.
module tb_div_radix2;
    localparam int W = 32;

    typedef struct {
        logic        sgn;
        logic [31:0] z;
        logic [31:0] d;
        logic [31:0] q;
        logic [31:0] s;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;
    vec_t vecs[15];

    always #5 clk = ~clk;

    div_radix2_if #(.WIDTH(W)) dif ();
    div_radix2 #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .div(dif.slave));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Cycles from the accept edge until DONE is visible.
    function automatic int exp_lat(input logic sgn, input logic [31:0] z);
`ifdef DIV_CLZ_SKIP_EN
        logic [31:0] za;
        int h;
        za = (sgn && z[31]) ? -z : z;
        h = -1;
        for (int i = 0; i < 32; i++) if (za[i]) h = i;
        return (h < 0) ? 1 : h + 2;
`else
        return (sgn | z[0]) ? 33 : 33;
`endif
    endfunction

    task automatic start(input logic sgn, input logic [31:0] z, input logic [31:0] d);
        @(negedge clk);
        dif.div_signed_i = sgn;
        dif.Z_i = z;
        dif.D_i = d;
        dif.div_valid = 1'b1;
        @(posedge clk);
        #1;
        dif.div_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!dif.res_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        start(v.sgn, v.z, v.d);
        wait_done(lat);
        check({name, ".lat"}, 32'(lat), 32'(exp_lat(v.sgn, v.z)));
        check({name, ".q"}, dif.q_o, v.q);
        check({name, ".s"}, dif.s_o, v.s);
        @(posedge clk);
        #1;
        check({name, ".idle"}, {30'd0, dif.div_ready, dif.res_valid}, 32'h2);
        check({name, ".qhold"}, dif.q_o, v.q);
    endtask

    initial begin
        int lat;
        logic [31:0] hq, hs;
        vec_t v;

        vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'h2,         32'hFFFFFFFD,  32'hFFFFFFFF};
        vecs[2]  = '{1'b1, 32'h7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'h1};
        vecs[3]  = '{1'b0, 32'hFFFFFFF9,  32'h2,         32'h7FFFFFFC,  32'h1};
        vecs[4]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h0};
        vecs[5]  = '{1'b0, 32'h1234,      32'h0,         32'hFFFFFFFF,  32'h1234};
        vecs[6]  = '{1'b1, 32'hFFFFFFF0,  32'h0,         32'hFFFFFFFF,  32'hFFFFFFF0};
        vecs[7]  = '{1'b0, 32'h0,         32'h9,         32'h0,         32'h0};
        vecs[8]  = '{1'b0, 32'h5,         32'h3,         32'h1,         32'h2};
        vecs[9]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'hE,         32'hFFFFFFFE};
        vecs[10] = '{1'b0, 32'hFFFFFFFF,  32'h1,         32'hFFFFFFFF,  32'h0};
        vecs[11] = '{1'b0, 32'h3,         32'hA,         32'h0,         32'h3};
        vecs[12] = '{1'b1, 32'h7FFFFFFF,  32'h10,        32'h07FFFFFF,  32'hF};
        vecs[13] = '{1'b1, 32'h40,        32'hFFFFFFFB,  32'hFFFFFFF4,  32'h4};
        vecs[14] = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h0,         32'h80000000};

        dif.div_valid = 1'b0;
        dif.div_signed_i = 1'b0;
        dif.Z_i = '0;
        dif.D_i = '0;
        dif.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.hs", {30'd0, dif.div_ready, dif.res_valid}, 32'h2);
        check("reset.q", dif.q_o, 32'h0);
        check("reset.s", dif.s_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_valid", {30'd0, dif.div_ready, dif.res_valid}, 32'h2);

        for (int i = 0; i < 15; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Result back-pressure: DONE holds until res_ready.
        dif.res_ready = 1'b0;
        start(1'b0, 32'd1000, 32'd33);
        wait_done(lat);
        check("hold.lat", 32'(lat), 32'(exp_lat(1'b0, 32'd1000)));
        hq = dif.q_o;
        hs = dif.s_o;
        check("hold.q", hq, 32'd30);
        check("hold.s", hs, 32'd10);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d.hs", k), {30'd0, dif.div_ready, dif.res_valid}, 32'h1);
            check($sformatf("hold%0d.q", k), dif.q_o, 32'd30);
            check($sformatf("hold%0d.s", k), dif.s_o, 32'd10);
        end
        @(negedge clk);
        dif.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold.release", {30'd0, dif.div_ready, dif.res_valid}, 32'h2);

        // Operand inputs wiggle while busy; the result must ignore them.
        start(1'b1, 32'hFFFFFF9C, 32'd7);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            dif.Z_i = $urandom;
            dif.D_i = $urandom;
            dif.div_signed_i = ~dif.div_signed_i;
        end
        wait_done(lat);
        check("toggle.valid", {31'd0, dif.res_valid}, 32'h1);
        check("toggle.q", dif.q_o, 32'hFFFFFFF2);
        check("toggle.s", dif.s_o, 32'hFFFFFFFE);
        @(posedge clk);
        #1;

        // Flush mid-CALC: reset asserted during cycle T+10.
        start(1'b0, 32'h12345678, 32'h3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("flush.hs", {30'd0, dif.div_ready, dif.res_valid}, 32'h2);
        check("flush.q", dif.q_o, 32'h0);
        check("flush.s", dif.s_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0};
        run_vec("after_flush", v);

        // Random operands against the language's own truncating division.
        for (int i = 0; i < 40; i++) begin
            v.sgn = 1'($urandom & 1);
            v.z = $urandom;
            v.d = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i % 4 == 0) v.z = v.z >> $urandom_range(0, 31);
            if (v.d == 0) v.d = 1;
            if (v.sgn && v.z == 32'h80000000 && v.d == 32'hFFFFFFFF) v.d = 3;
            if (v.sgn) begin
                v.q = $signed(v.z) / $signed(v.d);
                v.s = $signed(v.z) % $signed(v.d);
            end else begin
                v.q = v.z / v.d;
                v.s = v.z % v.d;
            end
            run_vec($sformatf("rnd%0d", i), v);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
